// File: rtl/lfsr5_seq_checker.sv
// Self-synchronising checker for a 5-bit internal-XOR LFSR (x^5+x^2+1).
// Hunts for a nonzero word, verifies LOCK_CNT predictions, then flywheels and counts errors.
module lfsr5_seq_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       in_state,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             zero_err,
  output logic [ERR_W-1:0] err_count,
  output logic             seed_pulse
);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  localparam logic [3:0] LockCntW = 4'(LOCK_CNT);
  localparam logic [3:0] LossCntW = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ErrOne = {{(ERR_W-1){1'b0}}, 1'b1};

  function automatic logic [4:0] lfsr_next(input logic [4:0] s);
    return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       expected_q, expected_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             zero_err_q, zero_err_d;
  logic             seed_pulse_q, seed_pulse_d;

  logic       is_zero, is_match;
  logic [3:0] match_inc, miss_inc;

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    zero_err_d   = 1'b0;
    seed_pulse_d = 1'b0;
    is_zero      = (in_state == 5'd0);
    is_match     = (in_state == expected_q) && !is_zero;
    match_inc    = match_cnt_q + 4'd1;
    miss_inc     = miss_cnt_q + 4'd1;

    if (in_valid) begin
      case (state_q)
        StHunt: begin
          if (is_zero) begin
            zero_err_d = 1'b1;
          end else begin
            expected_d  = lfsr_next(in_state);
            match_cnt_d = 4'd0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (is_zero) begin
            zero_err_d = 1'b1;
            state_d    = StHunt;
          end else begin
            expected_d = lfsr_next(in_state);
            if (is_match) begin
              match_cnt_d = match_inc;
              if (match_inc == LockCntW) begin
                state_d    = StLocked;
                miss_cnt_d = 4'd0;
              end
            end else begin
              match_cnt_d = 4'd0;
            end
          end
        end
        StLocked: begin
          // Flywheel: prediction advances from our own state, never from the input.
          expected_d = lfsr_next(expected_q);
          if (is_match) begin
            miss_cnt_d   = 4'd0;
            seed_pulse_d = (in_state == 5'b00001);
          end else begin
            err_pulse_d = 1'b1;
            zero_err_d  = is_zero;
            miss_cnt_d  = miss_inc;
            if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ErrOne;
            if (miss_inc == LossCntW) state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (clr_err) err_count_d = '0;
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StHunt;
      expected_q   <= 5'd0;
      match_cnt_q  <= 4'd0;
      miss_cnt_q   <= 4'd0;
      err_count_q  <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      zero_err_q   <= 1'b0;
      seed_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_count_q  <= err_count_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      zero_err_q   <= zero_err_d;
      seed_pulse_q <= seed_pulse_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign zero_err   = zero_err_q;
  assign err_count  = err_count_q;
  assign seed_pulse = seed_pulse_q;

endmodule

// File: doc/lfsr5_seq_checker.md
# lfsr5_seq_checker

Downstream consumer of the 5-bit internal-XOR LFSR (polynomial x^5+x^2+1, period 31). It samples the generator's parallel state word each valid cycle and self-synchronises to the sequence. Once locked, it flywheels its own prediction and counts mismatches. It gives a built-in pass/fail monitor for the pseudo-random source in test and BIST paths.

## Interface
- LOCK_CNT, default 4: consecutive correct predictions required to declare lock (1..15).
- LOSS_CNT, default 3: consecutive mispredictions while locked that drop lock (1..15).
- ERR_W, default 16: width of the saturating error counter.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- in_valid  input  1  qualifies in_state for this cycle.
- in_state  input  5  generator state word, bit 0 = S[0].
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  checker is synchronised.
- err_pulse  output  1  one-cycle pulse per misprediction while locked.
- zero_err  output  1  one-cycle pulse when a valid all-zero word arrives (illegal LFSR state).
- err_count  output  ERR_W  mispredictions counted while locked; saturates at all-ones.
- seed_pulse  output  1  one-cycle pulse when a locked, correctly predicted word equals 5'b00001 (period marker).

## Operation
- Next-state function N(s), identical to the generator:
  - N0 = s4
  - N1 = s0
  - N2 = s1 ^ s4
  - N3 = s2
  - N4 = s3
- Registers:
  - expected[4:0]
  - match_cnt and miss_cnt, 4 bits each
  - state in {HUNT, VERIFY, LOCKED}
- All actions below occur only on cycles with in_valid=1. When in_valid=0, all registers hold and all pulses are 0.
- HUNT:
  - in_state≠0: expected←N(in_state), match_cnt←0, go to VERIFY.
  - in_state=0: zero_err pulse, stay in HUNT.
- VERIFY:
  - in_state==expected: match_cnt+1 and expected←N(in_state). If match_cnt+1==LOCK_CNT, go to LOCKED and clear miss_cnt.
  - Mismatch with in_state≠0: reseed, expected←N(in_state), match_cnt←0, stay in VERIFY.
  - in_state=0: zero_err pulse, go to HUNT.
- LOCKED:
  - expected←N(expected) on every valid, independent of input (flywheel).
  - Match: miss_cnt←0. If in_state==5'b00001, seed_pulse.
  - Mismatch: err_pulse, err_count+1 (saturating), miss_cnt+1. If miss_cnt+1==LOSS_CNT, go to HUNT.
  - An all-zero word in LOCKED is a mismatch and also pulses zero_err.
- Mismatches are counted only in LOCKED. HUNT and VERIFY never touch err_count.
- clr_err=1 sets err_count←0. When clr_err coincides with an increment, the clear wins and the result is 0. clr_err does not affect lock state.
- locked = (state==LOCKED), driven from a register.

## Timing
- Reset values (asynchronous, while reset=0):
  - state=HUNT, expected=0, match_cnt=0, miss_cnt=0
  - locked=0, err_pulse=0, zero_err=0, seed_pulse=0, err_count=0
- Outputs are registered. Each pulse appears in the cycle after the edge that sampled the causing word and lasts exactly one cycle.
- Lock latency: 1 seeding word + LOCK_CNT matching words. locked rises in the cycle after the edge that samples the LOCK_CNT-th match.
- Loss latency: locked falls in the cycle after the edge that samples the LOSS_CNT-th consecutive mismatch. That mismatch still produces err_pulse and is counted.
- Gaps in in_valid are transparent: prediction advances per valid word, not per clock.
- Reset deassertion mid-stream: the checker restarts from HUNT and resynchronises within 1+LOCK_CNT valid words.
- err_count at all-ones stays at all-ones on further errors. err_pulse still fires.

## Test plan
- Lock: after reset, feed 00001, 00010, 00100, 01000, 10000 with LOCK_CNT=4 -> locked=1 in the cycle after 10000 is sampled; err_count=0.
- Flywheel error: once locked on the sequence 10000→00101, inject 11111 in place of 00101, then resume with the correct 01010 -> one err_pulse, err_count=1, locked stays 1, subsequent words match.
- Loss of lock: once locked, feed three wrong words with LOSS_CNT=3 -> three err_pulses, err_count=3, locked=0 after the third; a fresh valid sequence relocks after 5 words.
- Zero word: feed 00000 in HUNT -> zero_err pulse, no lock progress. Feed 00000 in LOCKED -> zero_err and err_pulse together.
- Full period with gaps: run 62 words with random in_valid gaps -> seed_pulse exactly twice, 31 valid words apart; err_count=0.
- Counter edges: with ERR_W=4, force 20 locked errors with LOSS_CNT=15 and periodic resync -> err_count saturates at 15. Assert clr_err on the same cycle as an error -> err_count=0. Assert reset mid-lock -> all outputs 0 immediately.
